// File: rtl/fetch_prefetch_buffer_pkg.sv
// Shared definitions for the instruction prefetch buffer: widths, reset
// address, the bubble instruction shown while empty, and the entry layout.
package fetch_prefetch_buffer_pkg;

    localparam int XLEN = 32;

    // First fetch address after reset unless the instance overrides it
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // addi x0, x0, 0 -- presented on inst_o whenever the queue is empty
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    // One queued fetch result: the PC it was fetched from and the word itself
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Parametrised synchronous FIFO holding fetched {pc, inst} entries.
// Supports flush, and simultaneous push/pop (also when full).
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    // Flush discards any same-cycle push or pop; popping an empty queue is ignored
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count_reg != '0);

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = count_reg;

    // The issue credit rule must make a push into a full queue impossible
    assert property (@(posedge clk) disable iff (!rst_n)
        !(do_push && !do_pop && (count_reg == CW'(DEPTH))));

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential fetches with bounded
// outstanding requests, queues returned words with their PC, and on a
// redirect flushes the queue and squashes responses still in flight.
module fetch_prefetch_buffer
    import fetch_prefetch_buffer_pkg::*;
#(
    parameter int              XLEN      = fetch_prefetch_buffer_pkg::XLEN,
    parameter int              DEPTH     = 4,
    parameter int              MAX_OUTST = 2,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   redirect_i,
    input  logic [XLEN-1:0]        redirect_pc_i,
    output logic                   imem_req_o,
    output logic [XLEN-1:0]        imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [XLEN-1:0]        imem_rdata_i,
    output logic                   inst_valid_o,
    output logic [XLEN-1:0]        inst_o,
    output logic [XLEN-1:0]        pc_o,
    input  logic                   inst_ready_i,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int EW = 2 * XLEN;

    logic [XLEN-1:0] fetch_pc_reg;
    logic [XLEN-1:0] resp_pc_reg;
    logic [OW-1:0]   outst_reg;
    logic [OW-1:0]   outst_next;
    logic [OW-1:0]   drop_reg;
    logic [CW-1:0]   count;
    logic [CW:0]     occupancy;
    logic [EW-1:0]   head_entry;
    logic [XLEN-1:0] redirect_pc_aligned;
    logic            req;
    logic            grant;
    logic            resp_fire;
    logic            push;
    logic            pop;
    logic            unused_pc_bits;

    // Misaligned redirect targets are trapped upstream; the low bits are dropped here
    assign redirect_pc_aligned = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign unused_pc_bits      = ^redirect_pc_i[1:0];

    // Queued entries plus in-flight requests must never exceed the queue size,
    // so every accepted request is guaranteed a slot when its data returns.
    assign occupancy = {1'b0, count} + (CW+1)'(outst_reg);
    assign req       = rst_i && !redirect_i
                    && (occupancy < (CW+1)'(DEPTH))
                    && (outst_reg < OW'(MAX_OUTST));
    assign grant     = req && imem_gnt_i;

    // Responses with nothing outstanding are stray and ignored
    assign resp_fire  = imem_rvalid_i && (outst_reg != '0);
    assign push       = resp_fire && (drop_reg == '0) && !redirect_i;
    assign pop        = inst_valid_o && inst_ready_i;
    assign outst_next = outst_reg + OW'(grant) - OW'(resp_fire);

    // Fetch/response PCs, in-flight count and squash count
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            fetch_pc_reg <= RESET_PC;
            resp_pc_reg  <= RESET_PC;
            outst_reg    <= '0;
            drop_reg     <= '0;
        end else begin
            outst_reg <= outst_next;
            if (redirect_i) begin
                fetch_pc_reg <= redirect_pc_aligned;
                resp_pc_reg  <= redirect_pc_aligned;
                // everything still in flight after this cycle belongs to the old path
                drop_reg     <= outst_reg - OW'(resp_fire);
            end else begin
                if (grant) begin
                    fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
                end
                if (resp_fire) begin
                    if (drop_reg != '0) begin
                        drop_reg <= drop_reg - OW'(1);
                    end else begin
                        resp_pc_reg <= resp_pc_reg + XLEN'(4);
                    end
                end
            end
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .flush     (redirect_i),
        .push      (push),
        .push_data ({resp_pc_reg, imem_rdata_i}),
        .pop       (pop),
        .head_data (head_entry),
        .count     (count)
    );

    assign imem_req_o   = req;
    assign imem_addr_o  = fetch_pc_reg;
    assign inst_valid_o = (count != '0);
    assign inst_o       = inst_valid_o ? head_entry[XLEN-1:0] : XLEN'(INST_NOP);
    assign pc_o         = inst_valid_o ? head_entry[EW-1:XLEN] : '0;
    assign count_o      = count;

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Bench for the prefetch buffer: two configurations (4/2 and 8/4) share the
// same control stimulus; each has its own in-order memory and a queue-based
// reference model. Directed sequences pin literal values on the 4/2 instance.
module tb_fetch_prefetch_buffer;
    import fetch_prefetch_buffer_pkg::*;

    typedef struct {
        logic [31:0] addr;
        bit          live;
    } infl_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        gnt;
    logic        rvalid;
    logic        ready;

    int tests = 0;
    int fails = 0;

    logic [1:0]  req_w;
    logic [1:0]  valid_w;
    logic [31:0] addr_w [2];
    logic [31:0] inst_w [2];
    logic [31:0] pc_w   [2];
    logic [31:0] cnt_w  [2];

    always #5 clk = ~clk;

    // Contents of instruction memory at a given word address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h13C0_FFEE;
    endfunction

    task automatic chk(input int cfg, input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL cfg%0d %s: got 0x%h, expected 0x%h", cfg, name, act, exp);
        end
    endtask

    task automatic chk1(input int cfg, input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL cfg%0d %s: got %b, expected %b", cfg, name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
            localparam int DEP = (gi == 0) ? 4 : 8;
            localparam int MO  = (gi == 0) ? 2 : 4;
            localparam int CW  = $clog2(DEP) + 1;

            logic          req, valid;
            logic [31:0]   addr, inst, pc, rdata;
            logic [CW-1:0] count;

            fetch_prefetch_buffer #(
                .XLEN(32), .DEPTH(DEP), .MAX_OUTST(MO), .RESET_PC(32'h0)
            ) dut (
                .clk_i        (clk),
                .rst_i        (rst_n),
                .redirect_i   (redirect),
                .redirect_pc_i(redirect_pc),
                .imem_req_o   (req),
                .imem_addr_o  (addr),
                .imem_gnt_i   (gnt),
                .imem_rvalid_i(rvalid),
                .imem_rdata_i (rdata),
                .inst_valid_o (valid),
                .inst_o       (inst),
                .pc_o         (pc),
                .inst_ready_i (ready),
                .count_o      (count)
            );

            assign req_w[gi]   = req;
            assign valid_w[gi] = valid;
            assign addr_w[gi]  = addr;
            assign inst_w[gi]  = inst;
            assign pc_w[gi]    = pc;
            assign cnt_w[gi]   = 32'(count);

            // In-order memory: remembers granted addresses, answers the oldest on rvalid
            logic [31:0] mq [$];
            logic [31:0] front = '0;
            logic        has = 1'b0;
            assign rdata = has ? mem_word(front) : 32'hBAD0_0000;

            always @(posedge clk) begin : memory
                if (!rst_n) begin
                    mq.delete();
                end else begin
                    if (rvalid && mq.size() != 0) void'(mq.pop_front());
                    if (req && gnt) mq.push_back(addr);
                end
                has   <= (mq.size() != 0);
                front <= (mq.size() != 0) ? mq[0] : 32'h0;
            end

            // Reference model: queue of delivered entries, list of in-flight fetches
            infl_t        inf [$];
            fetch_entry_t fq  [$];
            logic [31:0]  npc = 32'h0;
            bit           started = 1'b0;

            always @(posedge clk) begin : model
                bit           exp_req;
                bit           resp;
                infl_t        e;
                fetch_entry_t t;
                if (!rst_n) begin
                    started = 1'b1;
                    inf.delete();
                    fq.delete();
                    npc = 32'h0;
                end else begin
                    exp_req = !redirect && (fq.size() + inf.size() < DEP) && (inf.size() < MO);
                    resp    = rvalid && (inf.size() != 0);
                    e       = '{addr: 32'h0, live: 1'b0};
                    if (resp) e = inf.pop_front();
                    if (redirect) begin
                        foreach (inf[i]) inf[i].live = 1'b0;
                        fq.delete();
                        npc = {redirect_pc[31:2], 2'b00};
                    end else begin
                        if (fq.size() != 0 && ready) void'(fq.pop_front());
                        if (resp && e.live) begin
                            t.pc   = e.addr;
                            t.inst = rdata;
                            fq.push_back(t);
                        end
                        if (exp_req && gnt) begin
                            inf.push_back('{addr: npc, live: 1'b1});
                            npc = npc + 32'd4;
                        end
                    end
                end
            end

            always @(negedge clk) begin : compare
                bit er;
                if (started) begin
                    er = rst_n && !redirect && (fq.size() + inf.size() < DEP) && (inf.size() < MO);
                    chk1(gi, "req", req, er);
                    chk(gi, "addr", addr, npc);
                    chk1(gi, "valid", valid, fq.size() != 0);
                    chk(gi, "count", 32'(count), 32'(fq.size()));
                    chk(gi, "inst", inst, (fq.size() != 0) ? fq[0].inst : INST_NOP);
                    chk(gi, "pc", pc, (fq.size() != 0) ? fq[0].pc : 32'h0);
                end
            end
        end
    endgenerate

    initial begin
        logic [31:0] got [3];
        int          n;
        bit          found;

        rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        gnt = 1'b1; rvalid = 1'b1; ready = 1'b1;

        // Reset state and minimum latency
        repeat (3) step();
        @(negedge clk);
        chk1(0, "rst req", req_w[0], 1'b0);
        chk(0, "rst addr", addr_w[0], 32'h0);
        chk1(0, "rst valid", valid_w[0], 1'b0);
        chk(0, "rst count", cnt_w[0], 32'd0);
        step(); rst_n = 1'b1;
        @(negedge clk);
        chk1(0, "c0 req", req_w[0], 1'b1);
        chk(0, "c0 addr", addr_w[0], 32'h0);
        chk1(0, "c0 valid", valid_w[0], 1'b0);
        step(); @(negedge clk);
        chk(0, "c1 addr", addr_w[0], 32'h4);
        chk1(0, "c1 valid", valid_w[0], 1'b0);
        step(); @(negedge clk);
        chk1(0, "c2 valid", valid_w[0], 1'b1);
        chk(0, "c2 pc", pc_w[0], 32'h0);
        chk(0, "c2 inst", inst_w[0], mem_word(32'h0));
        step(); @(negedge clk);
        chk(0, "c3 pc", pc_w[0], 32'h4);
        step(); @(negedge clk);
        chk(0, "c4 pc", pc_w[0], 32'h8);

        // Fill with decode stalled, then drain in order
        step(); rst_n = 1'b0; ready = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (10) step();
        @(negedge clk);
        chk(0, "full count", cnt_w[0], 32'd4);
        chk1(0, "full req", req_w[0], 1'b0);
        step(); ready = 1'b1;
        @(negedge clk); chk(0, "drain pc0", pc_w[0], 32'h0);
        step(); @(negedge clk); chk(0, "drain pc1", pc_w[0], 32'h4);
        step(); @(negedge clk); chk(0, "drain pc2", pc_w[0], 32'h8);
        step(); @(negedge clk); chk(0, "drain pc3", pc_w[0], 32'hC);

        // Redirect with two queued and two in flight
        step(); rst_n = 1'b0; ready = 1'b0; rvalid = 1'b0; gnt = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;                 // cycle 0
        step();                       // cycle 1
        step(); rvalid = 1'b1;        // cycle 2
        step();                       // cycle 3
        step(); rvalid = 1'b0;        // cycle 4
        step(); redirect = 1'b1; redirect_pc = 32'h0000_0100;  // cycle 5
        @(negedge clk);
        chk(0, "pre-redir count", cnt_w[0], 32'd2);
        step(); redirect = 1'b0; rvalid = 1'b1; ready = 1'b1;
        @(negedge clk);
        chk1(0, "post-redir valid", valid_w[0], 1'b0);
        chk(0, "post-redir addr", addr_w[0], 32'h100);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(); @(negedge clk);
            if (valid_w[0]) found = 1'b1;
        end
        chk1(0, "redir valid timeout", found, 1'b1);
        chk(0, "redir first pc", pc_w[0], 32'h100);
        chk(0, "redir first inst", inst_w[0], mem_word(32'h100));

        // Redirect coinciding with a response and a pop, one in flight
        step(); rst_n = 1'b0; gnt = 1'b1; rvalid = 1'b1; ready = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (6) step();
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        @(negedge clk);
        chk(0, "steady count", cnt_w[0], 32'd1);
        step(); redirect = 1'b0;
        @(negedge clk);
        chk1(0, "r+1 valid", valid_w[0], 1'b0);
        chk(0, "r+1 count", cnt_w[0], 32'd0);
        chk1(0, "r+1 req", req_w[0], 1'b1);
        chk(0, "r+1 addr", addr_w[0], 32'h200);
        step(); @(negedge clk);
        chk1(0, "r+2 valid", valid_w[0], 1'b0);
        step(); @(negedge clk);
        chk1(0, "r+3 valid", valid_w[0], 1'b1);
        chk(0, "r+3 pc", pc_w[0], 32'h200);
        chk(0, "r+3 inst", inst_w[0], mem_word(32'h200));

        // Grant withheld: request and address hold; redirect during the wait
        step(); gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0300;
        step(); redirect = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            step(); @(negedge clk);
            chk1(0, "stall req", req_w[0], 1'b1);
            chk(0, "stall addr", addr_w[0], 32'h300);
        end
        step(); redirect = 1'b1; redirect_pc = 32'h0000_0340;
        step(); redirect = 1'b0;
        @(negedge clk);
        chk(0, "stall redir addr", addr_w[0], 32'h340);
        chk1(0, "stall redir req", req_w[0], 1'b1);

        // Unaligned redirect near the top of memory, address wrap
        step(); gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFA;
        step(); redirect = 1'b0;
        got = '{32'hDEAD_DEAD, 32'hDEAD_DEAD, 32'hDEAD_DEAD};
        n = 0;
        for (int k = 0; k < 30 && n < 3; k++) begin
            @(negedge clk);
            if (req_w[0] && gnt) begin
                got[n] = addr_w[0];
                n++;
            end
            step();
        end
        chk(0, "wrap grants", 32'(n), 32'd3);
        chk(0, "wrap addr0", got[0], 32'hFFFF_FFF8);
        chk(0, "wrap addr1", got[1], 32'hFFFF_FFFC);
        chk(0, "wrap addr2", got[2], 32'h0000_0000);

        // Random traffic on both configurations
        for (int k = 0; k < 3000; k++) begin
            step();
            gnt      = ($urandom_range(0, 3) != 0);
            rvalid   = ($urandom_range(0, 3) != 0);
            ready    = ($urandom_range(0, 2) != 0);
            redirect = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0)
                redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else
                redirect_pc = $urandom();
            rst_n    = ($urandom_range(0, 499) != 0);
        end
        step(); rst_n = 1'b1; redirect = 1'b0;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
